xcvr_rst_seq: RTL and testbench
===============================

XCVR_RST_SEQ -- requirements
Module: xcvr_rst_seq

Interface
REQ-001 SHALL have parameter T_PLLPD, default 16: pll_powerdown_o hold time, in cycles.
REQ-002 SHALL have parameter T_RX_ANA, default 16: minimum rx_analogreset_o hold time, in cycles.
REQ-003 SHALL have parameter T_TX_DIG, default 32: delay from tx analog release to tx digital release, in cycles.
REQ-004 SHALL have parameter T_LTD, default 64: continuous lockedtodata cycles required before rx digital release.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port nreset, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port pll_locked_i, input, 1, transmit fPLL lock; asynchronous to clk.
REQ-008 SHALL have port tx_cal_busy_i, input, 1, TX calibration in progress; asynchronous.
REQ-009 SHALL have port rx_cal_busy_i, input, 1, RX calibration in progress; asynchronous.
REQ-010 SHALL have port rx_is_lockedtodata_i, input, 1, CDR locked to data; asynchronous.
REQ-011 SHALL have port pll_powerdown_o, output, 1, fPLL powerdown.
REQ-012 SHALL have ports tx_analogreset_o, tx_digitalreset_o, tx_ready_o; each output, 1; TX analog reset, TX digital reset, TX ready.
REQ-013 SHALL have ports rx_analogreset_o, rx_digitalreset_o, rx_ready_o; each output, 1; RX analog reset, RX digital reset, RX ready.

Function
REQ-014 SHALL pass each of the 4 status inputs through a 2-flop synchronizer; "sync" below means the synchronizer output (2-cycle input latency).
REQ-015 SHALL implement two independent Moore FSMs, TX and RX; every output SHALL be a registered decode of FSM state, so outputs change 1 cycle after the transition condition holds.
REQ-016 SHALL give each FSM its own counter; the counter clears on state entry; "held T cycles" means the transition fires when count == T-1 and the condition is true.
REQ-017 TX states: PWRDN, WAIT_PLL, ANA_REL, READY.
REQ-018 PWRDN: pll_powerdown=1, tx_analogreset=1, tx_digitalreset=1, tx_ready=0; leaves to WAIT_PLL after T_PLLPD cycles.
REQ-019 WAIT_PLL: pll_powerdown=0, both TX resets=1; goes to ANA_REL when sync pll_locked=1 and sync tx_cal_busy=0.
REQ-020 ANA_REL: tx_analogreset=0, tx_digitalreset=1; goes to READY after T_TX_DIG cycles.
REQ-021 READY: both TX resets=0, tx_ready=1.
REQ-022 In ANA_REL or READY, sync pll_locked=0 or sync tx_cal_busy=1 SHALL return TX to WAIT_PLL, which reasserts both TX resets and clears tx_ready.
REQ-023 RX states: ANA, WAIT_LOCK, READY.
REQ-024 ANA: rx_analogreset=1, rx_digitalreset=1, rx_ready=0; goes to WAIT_LOCK once T_RX_ANA cycles have elapsed and sync rx_cal_busy=0; count saturates while cal is busy.
REQ-025 WAIT_LOCK: rx_analogreset=0, rx_digitalreset=1; counter counts while sync lockedtodata=1 and clears to 0 whenever it is 0; goes to READY after T_LTD consecutive locked cycles.
REQ-026 READY: both RX resets=0, rx_ready=1.
REQ-027 In READY, sync lockedtodata=0 SHALL return RX to WAIT_LOCK (digital reset only).
REQ-028 In WAIT_LOCK or READY, sync rx_cal_busy=1 SHALL return RX to ANA; cal_busy takes priority over lock loss when both occur in the same cycle.
REQ-029 The RX FSM SHALL NOT depend on TX state (independent CDR refclk).
REQ-030 Each counter SHALL be $clog2 of its largest threshold +1 bits wide and SHALL never wrap.
REQ-031 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-032 nreset=0 SHALL asynchronously force TX=PWRDN, RX=ANA, counters=0, synchronizers=0, and outputs pll_powerdown=1, all resets=1, both ready=0.
REQ-033 Release of nreset SHALL be synchronized externally; reset asserted mid-sequence SHALL restart both FSMs from their initial states.

Verification
REQ-034 Reset; pll_locked=1, cal_busy=0 throughout -> pll_powerdown falls at cycle 16, tx_analogreset falls at about cycle 19, tx_ready rises 32 cycles later.
REQ-035 Lockedtodata toggles 0 after 40 locked cycles, then stays at 1 -> rx_ready asserts only after 64 uninterrupted locked cycles.
REQ-036 pll_locked drops for 1 cycle while TX is READY -> tx_ready=0 and tx_digitalreset=1 within 4 cycles, and the full T_TX_DIG delay repeats.
REQ-037 rx_cal_busy=1 for 100 cycles from reset -> rx_analogreset stays 1 until 3 cycles after cal_busy falls.
REQ-038 Same-cycle rx_cal_busy rise and lockedtodata fall while RX is READY -> RX enters ANA, with rx_analogreset=1 and rx_ready=0.
REQ-039 nreset pulsed while TX is in ANA_REL -> all outputs return to their reset values asynchronously, and the sequence reruns from PWRDN.

Source files
------------

// File: rtl/xcvr_rst_seq_if.sv
// ----------------------------------------------------------------------------
// xcvr_rst_seq_if
// Groups the transceiver-facing signals of the reset sequencer into one bundle.
//
// Status from the transceiver (asynchronous to the sequencer clock):
//   pll_locked_i          transmit fPLL lock
//   tx_cal_busy_i         TX calibration in progress
//   rx_cal_busy_i         RX calibration in progress
//   rx_is_lockedtodata_i  CDR locked to incoming data
// Controls to the transceiver:
//   pll_powerdown_o       fPLL powerdown
//   tx_analogreset_o      TX analog reset
//   tx_digitalreset_o     TX digital reset
//   tx_ready_o            TX path usable
//   rx_analogreset_o      RX analog reset
//   rx_digitalreset_o     RX digital reset
//   rx_ready_o            RX path usable
//
// Modports:
//   master  the reset sequencer (drives the controls, reads the status)
//   slave   the transceiver side (drives the status, reads the controls)
// ----------------------------------------------------------------------------
interface xcvr_rst_seq_if;
    logic pll_locked_i;
    logic tx_cal_busy_i;
    logic rx_cal_busy_i;
    logic rx_is_lockedtodata_i;

    logic pll_powerdown_o;
    logic tx_analogreset_o;
    logic tx_digitalreset_o;
    logic tx_ready_o;
    logic rx_analogreset_o;
    logic rx_digitalreset_o;
    logic rx_ready_o;

    modport master (
        input  pll_locked_i,
        input  tx_cal_busy_i,
        input  rx_cal_busy_i,
        input  rx_is_lockedtodata_i,
        output pll_powerdown_o,
        output tx_analogreset_o,
        output tx_digitalreset_o,
        output tx_ready_o,
        output rx_analogreset_o,
        output rx_digitalreset_o,
        output rx_ready_o
    );

    modport slave (
        output pll_locked_i,
        output tx_cal_busy_i,
        output rx_cal_busy_i,
        output rx_is_lockedtodata_i,
        input  pll_powerdown_o,
        input  tx_analogreset_o,
        input  tx_digitalreset_o,
        input  tx_ready_o,
        input  rx_analogreset_o,
        input  rx_digitalreset_o,
        input  rx_ready_o
    );
endinterface

// File: rtl/xcvr_rst_seq.sv
// ----------------------------------------------------------------------------
// xcvr_rst_seq
// Transceiver reset sequencer. Two independent Moore FSMs bring the TX and RX
// halves of a transceiver out of reset in the order the PHY requires:
//   TX: fPLL powerdown -> wait for PLL lock and TX cal -> release analog ->
//       wait T_TX_DIG -> release digital -> tx_ready
//   RX: hold analog reset for T_RX_ANA and until RX cal done -> release
//       analog -> wait for T_LTD consecutive lockedtodata cycles -> release
//       digital -> rx_ready
// The RX side never looks at TX state because the CDR runs from its own
// reference clock.
//
// Parameters (a value of 0 behaves as 1):
//   T_PLLPD   pll_powerdown_o hold time, cycles
//   T_RX_ANA  minimum rx_analogreset_o hold time, cycles
//   T_TX_DIG  tx analog release to tx digital release, cycles
//   T_LTD     consecutive lockedtodata cycles before rx digital release
//
// Ports:
//   clk     single clock for all logic
//   nreset  asynchronous active-low reset (release synchronized externally)
//   xcvr    xcvr_rst_seq_if.master bundle of status inputs / reset outputs
// ----------------------------------------------------------------------------
module xcvr_rst_seq #(
    parameter int unsigned T_PLLPD  = 16,
    parameter int unsigned T_RX_ANA = 16,
    parameter int unsigned T_TX_DIG = 32,
    parameter int unsigned T_LTD    = 64
) (
    input  logic           clk,
    input  logic           nreset,
    xcvr_rst_seq_if.master xcvr
);

    // Zero-length holds are promoted to a single cycle so every "last count"
    // constant below stays non-negative.
    localparam int unsigned PLLPD_E  = (T_PLLPD  == 0) ? 1 : T_PLLPD;
    localparam int unsigned RX_ANA_E = (T_RX_ANA == 0) ? 1 : T_RX_ANA;
    localparam int unsigned TX_DIG_E = (T_TX_DIG == 0) ? 1 : T_TX_DIG;
    localparam int unsigned LTD_E    = (T_LTD    == 0) ? 1 : T_LTD;

    localparam int unsigned TX_MAX = (PLLPD_E  > TX_DIG_E) ? PLLPD_E  : TX_DIG_E;
    localparam int unsigned RX_MAX = (RX_ANA_E > LTD_E)    ? RX_ANA_E : LTD_E;
    localparam int TX_CW = $clog2(TX_MAX) + 1;
    localparam int RX_CW = $clog2(RX_MAX) + 1;

    localparam logic [TX_CW-1:0] PLLPD_LAST  = TX_CW'(PLLPD_E - 1);
    localparam logic [TX_CW-1:0] TX_DIG_LAST = TX_CW'(TX_DIG_E - 1);
    localparam logic [RX_CW-1:0] RX_ANA_LAST = RX_CW'(RX_ANA_E - 1);
    localparam logic [RX_CW-1:0] LTD_LAST    = RX_CW'(LTD_E - 1);

    typedef enum logic [1:0] {
        TX_PWRDN    = 2'd0,
        TX_WAIT_PLL = 2'd1,
        TX_ANA_REL  = 2'd2,
        TX_READY    = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_ANA       = 2'd0,
        RX_WAIT_LOCK = 2'd1,
        RX_READY     = 2'd2
    } rx_state_t;

    // Output vectors: TX = {pll_powerdown, tx_analogreset, tx_digitalreset,
    // tx_ready}, RX = {rx_analogreset, rx_digitalreset, rx_ready}.
    function automatic logic [3:0] tx_decode(input tx_state_t s);
        case (s)
            TX_PWRDN:    tx_decode = 4'b1110;
            TX_WAIT_PLL: tx_decode = 4'b0110;
            TX_ANA_REL:  tx_decode = 4'b0010;
            TX_READY:    tx_decode = 4'b0001;
            default:     tx_decode = 4'b1110;
        endcase
    endfunction

    function automatic logic [2:0] rx_decode(input rx_state_t s);
        case (s)
            RX_ANA:       rx_decode = 3'b110;
            RX_WAIT_LOCK: rx_decode = 3'b010;
            RX_READY:     rx_decode = 3'b001;
            default:      rx_decode = 3'b110;
        endcase
    endfunction

    logic [3:0] sync_meta;
    logic [3:0] sync_q;
    logic       pll_locked_s;
    logic       tx_cal_busy_s;
    logic       rx_cal_busy_s;
    logic       lockedtodata_s;
    logic       tx_link_ok;

    tx_state_t        tx_state;
    logic [TX_CW-1:0] tx_cnt;
    logic [3:0]       tx_out;

    rx_state_t        rx_state;
    logic [RX_CW-1:0] rx_cnt;
    logic [2:0]       rx_out;

    // Two-flop synchronizers for all four asynchronous status inputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {xcvr.pll_locked_i, xcvr.tx_cal_busy_i,
                          xcvr.rx_cal_busy_i, xcvr.rx_is_lockedtodata_i};
            sync_q    <= sync_meta;
        end
    end

    assign pll_locked_s   = sync_q[3];
    assign tx_cal_busy_s  = sync_q[2];
    assign rx_cal_busy_s  = sync_q[1];
    assign lockedtodata_s = sync_q[0];
    assign tx_link_ok     = pll_locked_s & ~tx_cal_busy_s;

    // TX sequencer. Outputs are loaded with the decode of the state being
    // entered, so they move on the same edge as the state register. Losing
    // PLL lock or starting a TX calibration after analog release drops back
    // to WAIT_PLL, which forces the full T_TX_DIG wait to run again.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_state <= TX_PWRDN;
            tx_cnt   <= '0;
            tx_out   <= 4'b1110;
        end else begin
            case (tx_state)
                TX_PWRDN: begin
                    if (tx_cnt == PLLPD_LAST) begin
                        tx_state <= TX_WAIT_PLL;
                        tx_cnt   <= '0;
                        tx_out   <= tx_decode(TX_WAIT_PLL);
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_WAIT_PLL: begin
                    if (tx_link_ok) begin
                        tx_state <= TX_ANA_REL;
                        tx_cnt   <= '0;
                        tx_out   <= tx_decode(TX_ANA_REL);
                    end
                end
                TX_ANA_REL: begin
                    if (!tx_link_ok) begin
                        tx_state <= TX_WAIT_PLL;
                        tx_cnt   <= '0;
                        tx_out   <= tx_decode(TX_WAIT_PLL);
                    end else if (tx_cnt == TX_DIG_LAST) begin
                        tx_state <= TX_READY;
                        tx_cnt   <= '0;
                        tx_out   <= tx_decode(TX_READY);
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_READY: begin
                    if (!tx_link_ok) begin
                        tx_state <= TX_WAIT_PLL;
                        tx_cnt   <= '0;
                        tx_out   <= tx_decode(TX_WAIT_PLL);
                    end
                end
                default: begin
                    tx_state <= TX_PWRDN;
                    tx_cnt   <= '0;
                    tx_out   <= tx_decode(TX_PWRDN);
                end
            endcase
        end
    end

    // RX sequencer. In ANA the counter saturates at its last value so a long
    // calibration simply extends the analog hold. In WAIT_LOCK any unlocked
    // cycle restarts the count, so only an uninterrupted run of T_LTD locked
    // cycles releases digital reset. Calibration outranks lock loss.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_state <= RX_ANA;
            rx_cnt   <= '0;
            rx_out   <= 3'b110;
        end else begin
            case (rx_state)
                RX_ANA: begin
                    if (rx_cnt == RX_ANA_LAST) begin
                        if (!rx_cal_busy_s) begin
                            rx_state <= RX_WAIT_LOCK;
                            rx_cnt   <= '0;
                            rx_out   <= rx_decode(RX_WAIT_LOCK);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_LOCK: begin
                    if (rx_cal_busy_s) begin
                        rx_state <= RX_ANA;
                        rx_cnt   <= '0;
                        rx_out   <= rx_decode(RX_ANA);
                    end else if (!lockedtodata_s) begin
                        rx_cnt <= '0;
                    end else if (rx_cnt == LTD_LAST) begin
                        rx_state <= RX_READY;
                        rx_cnt   <= '0;
                        rx_out   <= rx_decode(RX_READY);
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_READY: begin
                    if (rx_cal_busy_s) begin
                        rx_state <= RX_ANA;
                        rx_cnt   <= '0;
                        rx_out   <= rx_decode(RX_ANA);
                    end else if (!lockedtodata_s) begin
                        rx_state <= RX_WAIT_LOCK;
                        rx_cnt   <= '0;
                        rx_out   <= rx_decode(RX_WAIT_LOCK);
                    end
                end
                default: begin
                    rx_state <= RX_ANA;
                    rx_cnt   <= '0;
                    rx_out   <= rx_decode(RX_ANA);
                end
            endcase
        end
    end

    assign xcvr.pll_powerdown_o   = tx_out[3];
    assign xcvr.tx_analogreset_o  = tx_out[2];
    assign xcvr.tx_digitalreset_o = tx_out[1];
    assign xcvr.tx_ready_o        = tx_out[0];
    assign xcvr.rx_analogreset_o  = rx_out[2];
    assign xcvr.rx_digitalreset_o = rx_out[1];
    assign xcvr.rx_ready_o        = rx_out[0];

endmodule

// File: tb/tb_xcvr_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_xcvr_rst_seq
// Scoreboard bench for xcvr_rst_seq with default parameters. The stimulus
// process pushes every expected output change (cycle stamp + new vector) of
// the TX and RX channels into two queues; a monitor pops and compares each
// time a channel's outputs actually change. Cycle stamps count rising edges
// since the last nreset release (0 while in reset).
// TX vector = {pll_powerdown, tx_analogreset, tx_digitalreset, tx_ready}
// RX vector = {rx_analogreset, rx_digitalreset, rx_ready}
// ----------------------------------------------------------------------------
module tb_xcvr_rst_seq;

    logic clk        = 1'b0;
    logic nreset     = 1'b1;
    int   cyc        = 0;
    int   n_compared = 0;
    int   n_mismatch = 0;
    bit   mon_enable = 1'b0;

    typedef struct {
        string name;
        int    cyc;
        int    vec;
    } exp_t;

    exp_t tx_q[$];
    exp_t rx_q[$];

    xcvr_rst_seq_if bus ();

    xcvr_rst_seq dut (
        .clk    (clk),
        .nreset (nreset),
        .xcvr   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0b (%0d), expected %0b (%0d)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input bit pll, input bit tx_cal, input bit rx_cal, input bit ltd);
        bus.pll_locked_i         = pll;
        bus.tx_cal_busy_i        = tx_cal;
        bus.rx_cal_busy_i        = rx_cal;
        bus.rx_is_lockedtodata_i = ltd;
    endtask

    task automatic expectTx(input string name, input int c, input int v);
        exp_t e;
        e.name = name;
        e.cyc  = c;
        e.vec  = v;
        tx_q.push_back(e);
    endtask

    task automatic expectRx(input string name, input int c, input int v);
        exp_t e;
        e.name = name;
        e.cyc  = c;
        e.vec  = v;
        rx_q.push_back(e);
    endtask

    // Returns 2 time units after the rising edge that makes cyc == k.
    task automatic waitCyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    function automatic int txVec();
        return int'({bus.pll_powerdown_o, bus.tx_analogreset_o,
                     bus.tx_digitalreset_o, bus.tx_ready_o});
    endfunction

    function automatic int rxVec();
        return int'({bus.rx_analogreset_o, bus.rx_digitalreset_o, bus.rx_ready_o});
    endfunction

    // Asserts nreset between edges, checks the asynchronous reset values
    // before any further clock edge, then releases after hold_cycles edges.
    task automatic resetDut(input int hold_cycles, input bit push_exp, input string tag);
        @(posedge clk);
        #2;
        if (push_exp) begin
            expectTx({tag, "_reset"}, 0, 4'b1110);
            expectRx({tag, "_reset"}, 0, 3'b110);
        end
        nreset = 1'b0;
        #1;
        checkOutput({tag, "_async_tx"}, txVec(), 4'b1110);
        checkOutput({tag, "_async_rx"}, rxVec(), 3'b110);
        repeat (hold_cycles) @(posedge clk);
        #2;
        nreset = 1'b1;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_tx_pending"}, tx_q.size(), 0);
        checkOutput({tag, "_rx_pending"}, rx_q.size(), 0);
        tx_q.delete();
        rx_q.delete();
    endtask

    // Monitor: compares each observed output change against the next queued
    // expectation for that channel, both vector and cycle stamp.
    initial begin
        int   prev_tx;
        int   prev_rx;
        int   cur_tx;
        int   cur_rx;
        exp_t e;
        wait (mon_enable);
        prev_tx = 4'b1110;
        prev_rx = 3'b110;
        forever begin
            @(negedge clk or negedge nreset);
            #1;
            cur_tx = txVec();
            cur_rx = rxVec();
            if (cur_tx != prev_tx) begin
                if (tx_q.size() == 0) begin
                    n_compared++;
                    n_mismatch++;
                    $display("[TB] FAIL tx_unexpected: got %0b at cycle %0d, expected no change",
                             cur_tx, cyc);
                end else begin
                    e = tx_q.pop_front();
                    checkOutput({"tx_", e.name}, cur_tx, e.vec);
                    checkOutput({"tx_", e.name, "_cycle"}, cyc, e.cyc);
                end
                prev_tx = cur_tx;
            end
            if (cur_rx != prev_rx) begin
                if (rx_q.size() == 0) begin
                    n_compared++;
                    n_mismatch++;
                    $display("[TB] FAIL rx_unexpected: got %0b at cycle %0d, expected no change",
                             cur_rx, cyc);
                end else begin
                    e = rx_q.pop_front();
                    checkOutput({"rx_", e.name}, cur_rx, e.vec);
                    checkOutput({"rx_", e.name, "_cycle"}, cyc, e.cyc);
                end
                prev_rx = cur_rx;
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        n_mismatch++;
        $display("[TB] FAIL watchdog: got no end of stimulus, expected finish within 5000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #3;
        resetDut(3, 1'b0, "init");
        mon_enable = 1'b1;

        // Scenario 1: clean bring-up, then one-cycle PLL lock drop in TX READY,
        // then one-cycle lockedtodata drop in RX READY.
        expectTx("s1_pwrdn_exit", 16,  4'b0110);
        expectTx("s1_ana_rel",    17,  4'b0010);
        expectTx("s1_ready",      49,  4'b0001);
        expectTx("s1_pll_drop",   93,  4'b0110);
        expectTx("s1_ana_rel2",   94,  4'b0010);
        expectTx("s1_ready2",     126, 4'b0001);
        expectRx("s1_wait_lock",  16,  3'b010);
        expectRx("s1_ready",      80,  3'b001);
        expectRx("s1_lock_loss",  133, 3'b010);
        expectRx("s1_ready2",     197, 3'b001);
        waitCyc(90);
        bus.pll_locked_i = 1'b0;
        waitCyc(91);
        bus.pll_locked_i = 1'b1;
        waitCyc(130);
        bus.rx_is_lockedtodata_i = 1'b0;
        waitCyc(131);
        bus.rx_is_lockedtodata_i = 1'b1;
        waitCyc(205);
        checkDrained("s1");

        // Scenario 2: lockedtodata glitch after 40 locked cycles restarts the
        // 64-cycle qualification window.
        resetDut(3, 1'b1, "s2");
        expectTx("s2_pwrdn_exit", 16,  4'b0110);
        expectTx("s2_ana_rel",    17,  4'b0010);
        expectTx("s2_ready",      49,  4'b0001);
        expectRx("s2_wait_lock",  16,  3'b010);
        expectRx("s2_ready",      123, 3'b001);
        waitCyc(56);
        bus.rx_is_lockedtodata_i = 1'b0;
        waitCyc(57);
        bus.rx_is_lockedtodata_i = 1'b1;
        waitCyc(130);
        checkDrained("s2");

        // Scenario 3: RX cal busy for 100 cycles from reset, then simultaneous
        // cal start and lock loss while RX is READY.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        resetDut(3, 1'b1, "s3");
        expectTx("s3_pwrdn_exit", 16,  4'b0110);
        expectTx("s3_ana_rel",    17,  4'b0010);
        expectTx("s3_ready",      49,  4'b0001);
        expectRx("s3_cal_done",   103, 3'b010);
        expectRx("s3_ready",      167, 3'b001);
        expectRx("s3_cal_wins",   178, 3'b110);
        expectRx("s3_wait_lock2", 194, 3'b010);
        expectRx("s3_ready2",     258, 3'b001);
        waitCyc(100);
        bus.rx_cal_busy_i = 1'b0;
        waitCyc(175);
        bus.rx_cal_busy_i        = 1'b1;
        bus.rx_is_lockedtodata_i = 1'b0;
        waitCyc(185);
        bus.rx_cal_busy_i        = 1'b0;
        bus.rx_is_lockedtodata_i = 1'b1;
        waitCyc(265);
        checkDrained("s3");

        // Scenario 4: reset pulsed while TX is in ANA_REL, full sequence reruns.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        resetDut(3, 1'b1, "s4a");
        expectTx("s4_pwrdn_exit", 16, 4'b0110);
        expectTx("s4_ana_rel",    17, 4'b0010);
        expectRx("s4_wait_lock",  16, 3'b010);
        waitCyc(30);
        resetDut(2, 1'b1, "s4b");
        expectTx("s4_pwrdn_exit2", 16, 4'b0110);
        expectTx("s4_ana_rel2",    17, 4'b0010);
        expectTx("s4_ready2",      49, 4'b0001);
        expectRx("s4_wait_lock2",  16, 3'b010);
        expectRx("s4_ready2",      80, 3'b001);
        waitCyc(90);
        checkDrained("s4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
